// File: rtl/parity_frame_accumulator.sv
// parity_frame_accumulator
// Accumulates per-lane and overall parity over a frame of up to FRAME_LEN
// words received on a valid/ready stream. It presents the frame result on
// a held valid/ready output port.
module parity_frame_accumulator #(
  parameter int WIDTH     = 3,
  parameter int FRAME_LEN = 4,
  localparam int CW       = $clog2(FRAME_LEN + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  input  logic             flush,
  input  logic             odd_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_lane_par,
  output logic             out_par,
  output logic [CW-1:0]    out_count
);

  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] HOLD  = 1'b1;

  logic [0:0]       state;
  logic [WIDTH-1:0] acc;
  logic [CW-1:0]    cnt;

  logic             accept;
  logic             close;
  logic [WIDTH-1:0] acc_next;
  logic [CW-1:0]    cnt_next;

  // Both handshake outputs decode straight from the state register,
  // so no input reaches an output combinationally.
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == HOLD);

  // Work out this edge's accumulator and counter values, and whether the frame closes.
  always_comb begin
    accept   = in_valid && (state == ACCUM);
    acc_next = acc;
    cnt_next = cnt;
    if (accept) begin
      acc_next = acc ^ in_data;
      cnt_next = cnt + CW'(1);
    end
    close = (state == ACCUM) &&
            ((accept && (cnt == CW'(FRAME_LEN - 1))) || flush);
  end

  // Frame state, accumulator and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      out_lane_par <= '0;
      out_par      <= 1'b0;
      out_count    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (close) begin
            // A word accepted on the closing edge is part of the result.
            out_lane_par <= acc_next;
            out_count    <= cnt_next;
            out_par      <= (^acc_next) ^ odd_mode;
            acc          <= '0;
            cnt          <= '0;
            state        <= HOLD;
          end else begin
            acc <= acc_next;
            cnt <= cnt_next;
          end
        end
        HOLD: begin
          if (out_ready) state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_parity_frame_accumulator.sv
// Scoreboard bench for parity_frame_accumulator: the driver feeds a
// frame-level reference model and queues the expected results. The monitor
// checks each presented result and the handshake levels in every cycle.
module tb_parity_frame_accumulator;
  localparam int WIDTH     = 3;
  localparam int FRAME_LEN = 4;
  localparam int CW        = $clog2(FRAME_LEN + 1);

  typedef struct {
    logic [WIDTH-1:0] lane;
    logic             par;
    logic [CW-1:0]    count;
  } result_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             flush;
  logic             odd_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_lane_par;
  logic             out_par;
  logic [CW-1:0]    out_count;

  parity_frame_accumulator #(.WIDTH(WIDTH), .FRAME_LEN(FRAME_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .odd_mode(odd_mode),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_lane_par(out_lane_par), .out_par(out_par), .out_count(out_count)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  // Reference model: the words gathered so far in the open frame,
  // and whether a result is waiting to be consumed.
  logic [WIDTH-1:0] words[$];
  bit               m_hold  = 1'b0;
  bit               started = 1'b0;
  result_t          exp_q[$];

  task automatic chk(input string name, input int act, input int req);
    compared++;
    if (act != req) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic close_frame(input bit odd);
    result_t r;
    r.lane = '0;
    foreach (words[i]) r.lane ^= words[i];
    r.count = CW'(words.size());
    r.par   = ($countones(r.lane) % 2 == 1) ^ odd;
    exp_q.push_back(r);
    words.delete();
    m_hold = 1'b1;
  endtask

  // Apply one cycle of stimulus at the falling edge and advance the model
  // to match the state that follows the next rising edge.
  task automatic drive(input bit v, input logic [WIDTH-1:0] d, input bit f,
                       input bit odd, input bit ordy);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    flush     = f;
    odd_mode  = odd;
    out_ready = ordy;
    if (!m_hold) begin
      if (v) words.push_back(d);
      if ((v && words.size() == FRAME_LEN) || f) close_frame(odd);
    end else if (ordy) begin
      m_hold = 1'b0;
    end
  endtask

  // Monitor: checks handshake levels each cycle and pops a result when out_valid rises.
  initial begin
    bit      prev_valid = 1'b0;
    result_t cur;
    cur.lane = '0; cur.par = 1'b0; cur.count = '0;
    forever begin
      @(posedge clk);
      #1;
      if (started && rst_n) begin
        chk("in_ready", int'(in_ready), int'(!m_hold));
        chk("out_valid", int'(out_valid), int'(m_hold));
        if (out_valid && !prev_valid) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1, 0);
          end else begin
            cur = exp_q.pop_front();
            chk("out_lane_par", int'(out_lane_par), int'(cur.lane));
            chk("out_par", int'(out_par), int'(cur.par));
            chk("out_count", int'(out_count), int'(cur.count));
          end
        end else if (out_valid) begin
          chk("held_lane_par", int'(out_lane_par), int'(cur.lane));
          chk("held_par", int'(out_par), int'(cur.par));
          chk("held_count", int'(out_count), int'(cur.count));
        end
        prev_valid = out_valid;
      end else begin
        prev_valid = 1'b0;
      end
    end
  end

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, int'(in_ready), 1);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_out_lane_par"}, int'(out_lane_par), 0);
    chk({tag, "_out_par"}, int'(out_par), 0);
    chk({tag, "_out_count"}, int'(out_count), 0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    odd_mode = 1'b0; out_ready = 1'b0;
    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n   = 1'b1;
    started = 1'b1;

    // Full frame, even parity: lanes 001, parity 1, count 4.
    drive(1, 3'b001, 0, 0, 1);
    drive(1, 3'b011, 0, 0, 1);
    drive(1, 3'b110, 0, 0, 1);
    drive(1, 3'b101, 0, 0, 1);
    drive(0, '0, 0, 0, 1);
    drive(0, '0, 0, 0, 1);

    // Same words, odd parity sampled on the closing edge.
    drive(1, 3'b001, 0, 0, 1);
    drive(1, 3'b011, 0, 0, 1);
    drive(1, 3'b110, 0, 0, 1);
    drive(1, 3'b101, 0, 1, 1);
    drive(0, '0, 0, 0, 1);

    // Early flush together with a word.
    drive(1, 3'b111, 0, 0, 1);
    drive(1, 3'b010, 1, 0, 1);
    drive(0, '0, 0, 0, 1);

    // Empty flushes, back to back, even then odd parity.
    drive(0, '0, 1, 0, 1);
    drive(0, '0, 0, 0, 1);
    drive(0, '0, 1, 1, 1);
    drive(0, '0, 0, 0, 1);

    // Backpressure: inputs must be ignored while the result is held.
    drive(1, 3'b100, 1, 0, 0);
    for (int i = 0; i < 5; i++) drive(1, 3'(i + 1), 1, 1, 0);
    drive(0, '0, 0, 0, 1);
    drive(1, 3'b011, 0, 0, 1);
    drive(0, '0, 1, 0, 1);
    drive(0, '0, 0, 0, 1);

    // Asynchronous reset in the middle of a frame.
    drive(1, 3'b111, 0, 0, 1);
    drive(1, 3'b001, 0, 0, 1);
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0;
    #1 rst_n = 1'b0;
    words.delete(); m_hold = 1'b0; exp_q.delete();
    #1 check_reset_values("async_reset");
    #1 rst_n = 1'b1;
    for (int i = 0; i < 4; i++) drive(1, 3'b100, 0, 0, 1);
    drive(0, '0, 0, 0, 1);

    // Randomised traffic.
    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 9) < 6, WIDTH'($urandom), $urandom_range(0, 9) == 0,
            1'($urandom), $urandom_range(0, 9) < 6);

    // Drain any open frame and the last result.
    drive(0, '0, 0, 0, 1);
    drive(0, '0, 0, 0, 1);
    drive(0, '0, 1, 0, 1);
    for (int i = 0; i < 4; i++) drive(0, '0, 0, 0, 1);
    @(posedge clk);
    #2;
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parity_frame_accumulator.md
# parity_frame_accumulator

Parametrised sequential successor to the three-input XOR parity gate. Accepts a stream of WIDTH-bit words over a valid/ready handshake and accumulates per-lane (column) parity and overall parity across a frame of up to FRAME_LEN words. A frame ends at the FRAME_LEN-th word or on an early flush. The result is then presented on a held valid/ready output port. The block sits between the lab's data source (switches or counter) and the display/checker logic.

## Interface
- WIDTH, 3: bits per input word; minimum 1.
- FRAME_LEN, 4: words per full frame; minimum 1.
- CW (localparam), $clog2(FRAME_LEN+1): width of the word counter and out_count.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  in_data is valid this cycle.
- in_data  in  WIDTH  input word.
- in_ready  out  1  block can accept a word or a flush.
- flush  in  1  close the current frame early. Qualified by in_ready.
- odd_mode  in  1  0 = even parity, 1 = odd parity. Applies to out_par only.
- out_valid  out  1  frame result valid.
- out_ready  in  1  consumer takes the result.
- out_lane_par  out  WIDTH  bit i = XOR of bit i over all words accepted in the frame.
- out_par  out  1  XOR-reduce of out_lane_par, inverted when odd_mode=1.
- out_count  out  CW  number of words accepted in the frame (0..FRAME_LEN).

## Operation
- Two states:
  - ACCUM: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Internal registers: lane accumulator acc[WIDTH-1:0] and word counter cnt[CW-1:0].
- Reset value of every output:
  - in_ready=1, out_valid=0.
  - out_lane_par=0, out_par=0, out_count=0.
  - acc=0, cnt=0, state=ACCUM.
- ACCUM, accept (in_valid && in_ready): acc <= acc ^ in_data; cnt <= cnt+1.
- Frame close happens in ACCUM when either condition holds:
  - An accept occurs with cnt==FRAME_LEN-1.
  - flush=1 is seen.
- flush with in_valid on the same edge: the word is included first, then the frame closes.
- flush alone closes the frame with the current contents, including an empty frame (cnt=0).
- On the closing edge:
  - out_lane_par <= final acc value (including any word accepted on that edge).
  - out_count <= final count.
  - out_par <= (^final acc) ^ odd_mode, with odd_mode sampled on this edge.
  - State goes to HOLD; acc and cnt clear to 0.
- HOLD:
  - out_* registers are held stable.
  - in_valid, in_data, flush and odd_mode are ignored.
  - On an edge with out_ready=1: state returns to ACCUM. out_* data registers keep their values; only out_valid drops.
- cnt never exceeds FRAME_LEN and never wraps, because it is cleared on every close.
- Asynchronous reset mid-frame or in HOLD discards everything and restores the reset values immediately. The next frame counts from 0.

## Timing
- Accept latency: the word affects acc on the edge it is accepted. No combinational path from in_data to any output.
- Result latency: out_valid rises one cycle after the closing edge (it is a registered output of that edge).
- in_ready is a registered state decode:
  - It falls in the same cycle out_valid rises.
  - It returns one cycle after the out_ready handshake edge.
  - This gives exactly one bubble per frame.
- out_ready held high: out_valid is high for exactly 1 cycle.
- out_ready low: the result is held indefinitely.
- out_ready while out_valid=0 has no effect.
- Minimum frame period: FRAME_LEN+1 cycles for a full frame; 2 cycles for back-to-back empty flushes.

## Test plan
- Full frame, defaults, odd_mode=0: accept 001, 011, 110, 101 on consecutive cycles, out_ready=1. Require:
  - out_valid high 1 cycle after the 4th accept, for exactly 1 cycle.
  - out_lane_par=001, out_par=1, out_count=4.
  - in_ready=0 for exactly 1 cycle.
- Same four words with odd_mode=1 on the closing edge -> out_lane_par=001, out_par=0, out_count=4.
- Early flush: accept 111, then 010 with flush=1 on the same edge -> out_lane_par=101, out_par=0, out_count=2.
- Empty flush: flush=1 with no words accepted.
  - odd_mode=0 -> out_lane_par=000, out_par=0, out_count=0.
  - Repeat with odd_mode=1 -> out_par=1.
- Backpressure: close a frame, hold out_ready=0 for 5 cycles while driving in_valid=1 and flush=1. Require:
  - Outputs stable, in_ready=0, no words counted.
  - After out_ready=1: in_ready=1 on the next cycle, and the next frame starts at cnt=0.
- Reset mid-frame: accept 2 words, pulse rst_n low between edges. Require:
  - All outputs return to their reset values without waiting for a clock edge.
  - A subsequent full frame of 100, 100, 100, 100 gives out_lane_par=000, out_par=0, out_count=4.
